// File: rtl/aes_sbox_pkg.sv
// Shared types and constants for the S-box sharing controller.
package aes_sbox_pkg;

  typedef logic [15:0][7:0] state_t;
  typedef logic [3:0][7:0]  word_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} sbox_fsm_t;
  typedef enum logic       {REQ_ST, REQ_KEY}          sbox_req_t;

  localparam int N_ST  = 16;
  localparam int N_KEY = 4;

  // Index of the final ROM read for a job owned by r.
  function automatic logic [3:0] last_idx(sbox_req_t r);
    return (r == REQ_KEY) ? 4'(N_KEY - 1) : 4'(N_ST - 1);
  endfunction

endpackage

// File: rtl/sbox_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module sbox_rr_arb
  import aes_sbox_pkg::*;
(
  input  logic       req_st_i,
  input  logic       req_key_i,
  input  logic       en_i,
  input  sbox_req_t  last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_st_i && req_key_i) gnt_o = (last_i == REQ_KEY) ? 2'b01 : 2'b10;
      else                       gnt_o = {req_key_i, req_st_i};
    end
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Sequences SubBytes / SubWord jobs through one shared byte S-box ROM,
// one read per cycle, collecting results into per-requester registers.
module sbox_share_ctrl
  import aes_sbox_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_st,
  input  state_t     i_st,
  output logic       gnt_st,
  output logic       done_st,
  output state_t     o_st,
  input  logic       req_key,
  input  word_t      i_key,
  output logic       gnt_key,
  output logic       done_key,
  output word_t      o_key,
  output logic       rom_en,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data
);

  if (ROM_LAT != 1) begin : g_lat_chk
    $error("sbox_share_ctrl: only ROM_LAT=1 is supported");
  end

  sbox_fsm_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  sbox_req_t  last_q, own_q;
  state_t     buf_q;
  logic       wr_vld_q;
  logic [3:0] wr_idx_q;
  state_t     o_st_q;
  word_t      o_key_q;
  logic [1:0] gnt;

  // Gating with resetn keeps grants quiet while reset is held.
  sbox_rr_arb u_arb (
    .req_st_i  (req_st),
    .req_key_i (req_key),
    .en_i      ((state_q == S_IDLE) && resetn),
    .last_i    (last_q),
    .gnt_o     (gnt)
  );

  assign gnt_st   = gnt[0];
  assign gnt_key  = gnt[1];
  assign done_st  = (state_q == S_DRAIN) && (own_q == REQ_ST);
  assign done_key = (state_q == S_DRAIN) && (own_q == REQ_KEY);
  assign rom_en   = (state_q == S_ISSUE);
  assign rom_addr = rom_en ? buf_q[cnt_q] : 8'h00;
  assign o_st     = o_st_q;
  assign o_key    = o_key_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (cnt_q == last_idx(own_q)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= REQ_KEY;
      own_q    <= REQ_ST;
      buf_q    <= '0;
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
      o_st_q   <= '0;
      o_key_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_vld_q <= rom_en;
      wr_idx_q <= rom_en ? cnt_q : 4'd0;
      if (gnt[0]) begin
        buf_q  <= i_st;
        own_q  <= REQ_ST;
        last_q <= REQ_ST;
      end else if (gnt[1]) begin
        buf_q  <= state_t'({96'b0, i_key});
        own_q  <= REQ_KEY;
        last_q <= REQ_KEY;
      end
      // ROM data lands one cycle after its read; own_q is stable until the next grant.
      if (wr_vld_q) begin
        if (own_q == REQ_ST) o_st_q[wr_idx_q]       <= rom_data;
        else                 o_key_q[wr_idx_q[1:0]] <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: AES S-box ROM model, job-level schedule model,
// table-driven directed jobs, reset-mid-job sequence and random jobs.
module tb_sbox_share_ctrl;
  import aes_sbox_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_st, req_key;
  state_t     i_st, o_st;
  word_t      i_key, o_key;
  logic       gnt_st, done_st, gnt_key, done_key;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;

  int n_pass = 0;
  int n_tot  = 0;

  state_t m_st;
  word_t  m_key;
  bit     m_last_key;

  logic [0:255][7:0] sbox_v = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  sbox_share_ctrl #(.ROM_LAT(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_st   (req_st),
    .i_st     (i_st),
    .gnt_st   (gnt_st),
    .done_st  (done_st),
    .o_st     (o_st),
    .req_key  (req_key),
    .i_key    (i_key),
    .gnt_key  (gnt_key),
    .done_key (done_key),
    .o_key    (o_key),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) if (rom_en) rom_data <= sbox_v[rom_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic state_t sub_st(input state_t s);
    state_t r;
    for (int k = 0; k < N_ST; k++) r[k] = sbox_v[s[k]];
    return r;
  endfunction

  function automatic word_t sub_wd(input word_t w);
    word_t r;
    for (int k = 0; k < N_KEY; k++) r[k] = sbox_v[w[k]];
    return r;
  endfunction

  function automatic state_t mk_st(input logic [7:0] base, input logic [7:0] step);
    state_t r;
    for (int k = 0; k < N_ST; k++) r[k] = base + 8'(k) * step;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Runs one arbitration scenario. Cycle 0 is the first cycle requests are
  // visible; e_* are expected grant/done cycles (-1 = never).
  task automatic run_job(input string tag, input bit w_st, input bit w_key, input int key_at,
                         input state_t dst, input word_t dkey,
                         input int e_gst, input int e_dst, input int e_gk, input int e_dk);
    int gst, dsc, gk, dk, ngs, nds, ngk, ndk, rom_bad, ret_bad;
    bit gs_now, gk_now;
    logic e_en;
    logic [7:0] e_addr;
    state_t old_st;
    word_t old_key;
    gst = -1; dsc = -1; gk = -1; dk = -1;
    ngs = 0; nds = 0; ngk = 0; ndk = 0; rom_bad = 0; ret_bad = 0;
    old_st = m_st; old_key = m_key;
    i_st = dst; i_key = dkey;
    req_st = w_st;
    req_key = w_key && (key_at == 0);
    for (int c = 0; c < 80; c++) begin
      if (w_key && key_at > 0 && c == key_at) req_key = 1'b1;
      @(negedge clk);
      gs_now = gnt_st; gk_now = gnt_key;
      if (gnt_st)   begin ngs++; if (gst < 0) gst = c; end
      if (gnt_key)  begin ngk++; if (gk < 0)  gk = c;  end
      if (done_st)  begin nds++; if (dsc < 0) dsc = c; end
      if (done_key) begin ndk++; if (dk < 0)  dk = c;  end
      e_en = 1'b0; e_addr = 8'h00;
      if (w_st && c > e_gst && c <= e_gst + N_ST) begin e_en = 1'b1; e_addr = dst[c - e_gst - 1]; end
      if (w_key && c > e_gk && c <= e_gk + N_KEY) begin e_en = 1'b1; e_addr = dkey[c - e_gk - 1]; end
      if (rom_en !== e_en || rom_addr !== e_addr) rom_bad++;
      if (w_st && c == e_gst + 1 && o_st !== old_st) ret_bad++;
      if (w_key && c == e_gk + 1 && o_key !== old_key) ret_bad++;
      @(posedge clk); #1;
      if (gs_now) req_st = 1'b0;
      if (gk_now) req_key = 1'b0;
      if ((!w_st || dsc >= 0) && (!w_key || dk >= 0)) break;
    end
    req_st = 1'b0; req_key = 1'b0;
    @(negedge clk);
    if (done_st) nds++;
    if (done_key) ndk++;
    if (rom_en) rom_bad++;
    if (w_st) m_st = sub_st(dst);
    if (w_key) m_key = sub_wd(dkey);
    chk({tag, "_gnt_st_cycle"}, gst, e_gst);
    chk({tag, "_done_st_cycle"}, dsc, e_dst);
    chk({tag, "_gnt_key_cycle"}, gk, e_gk);
    chk({tag, "_done_key_cycle"}, dk, e_dk);
    chk({tag, "_pulse_counts"}, {ngs, nds, ngk, ndk}, {32'(w_st), 32'(w_st), 32'(w_key), 32'(w_key)});
    chk({tag, "_rom_trace_errs"}, rom_bad, 0);
    chk({tag, "_retain_errs"}, ret_bad, 0);
    chk({tag, "_o_st"}, o_st, m_st);
    chk({tag, "_o_key"}, o_key, m_key);
    if (w_st && w_key) m_last_key = (e_gk > e_gst);
    else if (w_key)    m_last_key = 1'b1;
    else if (w_st)     m_last_key = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit         w_st;
    bit         w_key;
    int         key_at;
    state_t     dst;
    word_t      dkey;
    int         gst, dstc, gk, dk;
    int         spot;
    logic [7:0] s0, s1, s15;
    word_t      sk;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int bad;
    req_st = 1'b0; req_key = 1'b0; i_st = '0; i_key = '0;
    resetn = 1'b0;
    m_st = '0; m_key = '0; m_last_key = 1'b1;

    tbl[0] = '{1, 1, 0, mk_st(8'hA0, 8'd3), 32'h01020304, 0, 17, 18, 23, 0, 8'h0, 8'h0, 8'h0, 32'h0};
    tbl[1] = '{1, 1, 0, mk_st(8'h11, 8'd5), 32'hdeadbeef, 0, 17, 18, 23, 0, 8'h0, 8'h0, 8'h0, 32'h0};
    tbl[2] = '{1, 0, 0, mk_st(8'h00, 8'd1), 32'h0, 0, 17, -1, -1, 1, 8'h63, 8'h7c, 8'h76, 32'h0};
    tbl[3] = '{0, 1, 0, '0, 32'h5300ff10, -1, -1, 0, 5, 2, 8'h0, 8'h0, 8'h0, 32'hed6316ca};
    tbl[4] = '{1, 0, 0, mk_st(8'h53, 8'd0), 32'h0, 0, 17, -1, -1, 0, 8'h0, 8'h0, 8'h0, 32'h0};
    tbl[5] = '{1, 1, 0, mk_st(8'h3c, 8'd11), 32'h7788aa99, 6, 23, 0, 5, 0, 8'h0, 8'h0, 8'h0, 32'h0};
    tbl[6] = '{1, 1, 5, mk_st(8'hc4, 8'd13), 32'h0a0b0c0d, 0, 17, 18, 23, 0, 8'h0, 8'h0, 8'h0, 32'h0};

    repeat (2) @(negedge clk);
    chk("reset_o_st", o_st, 0);
    chk("reset_o_key", o_key, 0);
    chk("reset_rom", {rom_en, rom_addr}, 0);
    chk("reset_pulses", {gnt_st, done_st, gnt_key, done_key}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_job($sformatf("tbl%0d", i), tbl[i].w_st, tbl[i].w_key, tbl[i].key_at, tbl[i].dst,
              tbl[i].dkey, tbl[i].gst, tbl[i].dstc, tbl[i].gk, tbl[i].dk);
      if (tbl[i].spot == 1) chk($sformatf("tbl%0d_spot_st", i), {o_st[0], o_st[1], o_st[15]},
                                {tbl[i].s0, tbl[i].s1, tbl[i].s15});
      if (tbl[i].spot == 2) chk($sformatf("tbl%0d_spot_key", i), o_key, tbl[i].sk);
    end

    // Reset asserted in cycle 8 of a state job.
    bad = 0;
    i_st = mk_st(8'h20, 8'd9); req_st = 1'b1;
    @(negedge clk);
    chk("rstmid_gnt", gnt_st, 1'b1);
    @(posedge clk); #1;
    req_st = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      if (done_st || !rom_en) bad++;
      @(posedge clk); #1;
    end
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_rom", {rom_en, rom_addr}, 0);
    chk("rstmid_pulses", {gnt_st, done_st, gnt_key, done_key}, 0);
    chk("rstmid_o_st", o_st, 0);
    chk("rstmid_o_key", o_key, 0);
    repeat (3) begin
      @(negedge clk);
      if (done_st || done_key || rom_en) bad++;
    end
    chk("rstmid_quiet_errs", bad, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    m_st = '0; m_key = '0; m_last_key = 1'b1;
    @(posedge clk); #1;
    run_job("post_rst_tie", 1, 1, 0, mk_st(8'h9e, 8'd7), 32'hc0ffee11, 0, 17, 18, 23);

    for (int it = 0; it < 24; it++) begin
      int mode, egs, eds, egk, edk;
      bit ws, wk;
      state_t rs;
      word_t rk;
      mode = $urandom_range(0, 2);
      for (int k = 0; k < N_ST; k++) rs[k] = 8'($urandom);
      rk = $urandom;
      ws = (mode != 1); wk = (mode != 0);
      egs = -1; eds = -1; egk = -1; edk = -1;
      if (ws && wk) begin
        if (m_last_key) begin
          egs = 0; eds = N_ST + 1; egk = N_ST + 2; edk = N_ST + 2 + N_KEY + 1;
        end else begin
          egk = 0; edk = N_KEY + 1; egs = N_KEY + 2; eds = N_KEY + 2 + N_ST + 1;
        end
      end else if (ws) begin
        egs = 0; eds = N_ST + 1;
      end else begin
        egk = 0; edk = N_KEY + 1;
      end
      run_job($sformatf("rnd%0d", it), ws, wk, 0, rs, rk, egs, eds, egk, edk);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
